// File: rtl/parking_gate_arbiter_if.sv
// Handshake bundle between lane controllers, the gate arbiter and the gate/display side.
interface parking_gate_arbiter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             entry_req;
  logic             exit_req;
  logic             car_passed;
  logic             grant_entry;
  logic             grant_exit;
  logic             gate_open;
  logic             entry_denied;
  logic             timeout;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;

  modport master (
    output entry_req, exit_req, car_passed,
    input  grant_entry, grant_exit, gate_open, entry_denied, timeout, occupancy, full, empty
  );

  modport slave (
    input  entry_req, exit_req, car_passed,
    output grant_entry, grant_exit, gate_open, entry_denied, timeout, occupancy, full, empty
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate arbiter: entry/exit round-robin, occupancy tracking, open timeout, guard.
// Define PARK_EXIT_PRIORITY_EN to make exit win every conflict instead of round-robin.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY       = 8,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GUARD_CYCLES   = 2
) (
  input logic                   clk,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int unsigned TmrMax = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned TW     = $clog2(TmrMax) + 1;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StOpenEntry = 2'd1;
  localparam logic [1:0] StOpenExit  = 2'd2;
  localparam logic [1:0] StClose     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             last_exit_q, last_exit_d;
  logic             grant_entry_q, grant_entry_d;
  logic             grant_exit_q, grant_exit_d;
  logic             gate_open_q, gate_open_d;
  logic             entry_denied_q, entry_denied_d;
  logic             timeout_q, timeout_d;

  logic full_w, empty_w, entry_elig, exit_elig, pick_entry;

  assign full_w     = (occ_q == CNT_W'(CAPACITY));
  assign empty_w    = (occ_q == '0);
  assign entry_elig = bus.entry_req && !full_w;
  assign exit_elig  = bus.exit_req && !empty_w;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    occ_d          = occ_q;
    last_exit_d    = last_exit_q;
    grant_entry_d  = 1'b0;
    grant_exit_d   = 1'b0;
    gate_open_d    = gate_open_q;
    entry_denied_d = 1'b0;
    timeout_d      = 1'b0;
    pick_entry     = 1'b0;

    case (state_q)
      StIdle: begin
        entry_denied_d = bus.entry_req && full_w;
        if (entry_elig || exit_elig) begin
`ifdef PARK_EXIT_PRIORITY_EN
          pick_entry = !exit_elig;
`else
          // Conflict goes to the lane not served last.
          pick_entry = entry_elig && (!exit_elig || last_exit_q);
`endif
          gate_open_d = 1'b1;
          timer_d     = '0;
          if (pick_entry) begin
            state_d       = StOpenEntry;
            grant_entry_d = 1'b1;
            last_exit_d   = 1'b0;
          end else begin
            state_d      = StOpenExit;
            grant_exit_d = 1'b1;
            last_exit_d  = 1'b1;
          end
        end
      end

      StOpenEntry, StOpenExit: begin
        timer_d = timer_q + TW'(1);
        if (bus.car_passed) begin
          occ_d       = (state_q == StOpenEntry) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
          state_d     = StClose;
          gate_open_d = 1'b0;
          timer_d     = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = StClose;
          gate_open_d = 1'b0;
          timeout_d   = 1'b1;
          timer_d     = '0;
        end
      end

      StClose: begin
        gate_open_d = 1'b0;
        if (timer_q == TW'(GUARD_CYCLES - 1)) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d     = StIdle;
        gate_open_d = 1'b0;
        timer_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      occ_q          <= '0;
      last_exit_q    <= 1'b1;
      grant_entry_q  <= 1'b0;
      grant_exit_q   <= 1'b0;
      gate_open_q    <= 1'b0;
      entry_denied_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      occ_q          <= occ_d;
      last_exit_q    <= last_exit_d;
      grant_entry_q  <= grant_entry_d;
      grant_exit_q   <= grant_exit_d;
      gate_open_q    <= gate_open_d;
      entry_denied_q <= entry_denied_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.grant_entry  = grant_entry_q;
  assign bus.grant_exit   = grant_exit_q;
  assign bus.gate_open    = gate_open_q;
  assign bus.entry_denied = entry_denied_q;
  assign bus.timeout      = timeout_q;
  assign bus.occupancy    = occ_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with CAPACITY=2, TIMEOUT_CYCLES=64, GUARD_CYCLES=2.
module tb_parking_gate_arbiter;

  localparam int unsigned Guard = 2;
`ifdef PARK_EXIT_PRIORITY_EN
  localparam int Prio = 1;
`else
  localparam int Prio = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cnt;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAPACITY      (2),
    .CNT_W         (4),
    .TIMEOUT_CYCLES(64),
    .GUARD_CYCLES  (Guard)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one car on a lane from IDLE: request, grant, pass after 'delay' cycles, guard.
  task automatic serve(input bit is_exit, input int delay);
    int got;
    got = 0;
    if (is_exit) bus.exit_req = 1'b1;
    else         bus.entry_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((is_exit && bus.grant_exit) || (!is_exit && bus.grant_entry)) begin
        got = 1;
        break;
      end
    end
    check("serve_grant", got, 1);
    bus.exit_req  = 1'b0;
    bus.entry_req = 1'b0;
    repeat (delay - 1) tick();
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    repeat (Guard) tick();
  endtask

  initial begin
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    tick();
    tick();
    check("rst_gate_open", int'(bus.gate_open), 0);
    check("rst_grant_entry", int'(bus.grant_entry), 0);
    check("rst_grant_exit", int'(bus.grant_exit), 0);
    check("rst_denied", int'(bus.entry_denied), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_occ", int'(bus.occupancy), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_empty", int'(bus.empty), 1);
    reset = 1'b0;

    // Single entry, passage 3 cycles after grant.
    bus.entry_req = 1'b1;
    tick();
    check("e1_grant", int'(bus.grant_entry), 1);
    check("e1_open", int'(bus.gate_open), 1);
    bus.entry_req = 1'b0;
    tick();
    check("e1_grant_pulse", int'(bus.grant_entry), 0);
    check("e1_open2", int'(bus.gate_open), 1);
    tick();
    check("e1_open3", int'(bus.gate_open), 1);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("e1_closed", int'(bus.gate_open), 0);
    check("e1_occ", int'(bus.occupancy), 1);
    check("e1_empty", int'(bus.empty), 0);
    // Next request is held off by the guard interval.
    bus.entry_req = 1'b1;
    tick();
    check("guard1_grant", int'(bus.grant_entry), 0);
    tick();
    check("guard2_grant", int'(bus.grant_entry), 0);
    tick();
    check("turnaround_grant", int'(bus.grant_entry), 1);
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("e2_occ", int'(bus.occupancy), 2);
    check("e2_full", int'(bus.full), 1);
    tick();
    tick();

    // Lot full: entry refused while waiting in IDLE.
    bus.entry_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_denied", int'(bus.entry_denied), 1);
      check("full_no_grant", int'(bus.grant_entry), 0);
    end
    bus.exit_req = 1'b1;
    tick();
    check("full_exit_grant", int'(bus.grant_exit), 1);
    check("full_exit_no_entry", int'(bus.grant_entry), 0);
    bus.exit_req = 1'b0;
    tick();
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("x1_occ", int'(bus.occupancy), 1);
    check("x1_full", int'(bus.full), 0);
    check("x1_denied", int'(bus.entry_denied), 0);

    // Conflict with last_served = exit, entry still held.
    bus.exit_req = 1'b1;
    tick();
    tick();
    tick();
    check("c1_grant_exit", int'(bus.grant_exit), Prio);
    check("c1_grant_entry", int'(bus.grant_entry), 1 - Prio);
    if (Prio != 0) bus.exit_req = 1'b0;
    else           bus.entry_req = 1'b0;
    tick();
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("c1_occ", int'(bus.occupancy), (Prio != 0) ? 0 : 2);
    tick();
    tick();
    tick();
    check("c1b_grant_exit", int'(bus.grant_exit), 1 - Prio);
    check("c1b_grant_entry", int'(bus.grant_entry), Prio);
    bus.exit_req   = 1'b0;
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("c1b_occ", int'(bus.occupancy), 1);
    tick();
    tick();

    // Second conflict, then let it time out.
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    tick();
    check("c2_grant_exit", int'(bus.grant_exit), Prio);
    check("c2_grant_entry", int'(bus.grant_entry), 1 - Prio);
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.gate_open) cnt++;
      else break;
    end
    check("to_open_cycles", cnt, 64);
    check("to_pulse", int'(bus.timeout), 1);
    check("to_occ", int'(bus.occupancy), 1);
    tick();
    check("to_pulse_end", int'(bus.timeout), 0);
    tick();

    // Passage on the last open cycle wins over the timeout.
    bus.entry_req = 1'b1;
    tick();
    check("late_grant", int'(bus.grant_entry), 1);
    bus.entry_req = 1'b0;
    repeat (63) tick();
    check("late_still_open", int'(bus.gate_open), 1);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    check("late_no_timeout", int'(bus.timeout), 0);
    check("late_occ", int'(bus.occupancy), 2);
    check("late_closed", int'(bus.gate_open), 0);
    tick();
    tick();

    // Reset while the gate is open for entry, with a passage pulse in flight.
    serve(1'b1, 2);
    check("pre_rst_occ", int'(bus.occupancy), 1);
    bus.entry_req = 1'b1;
    tick();
    check("rst2_grant", int'(bus.grant_entry), 1);
    bus.entry_req = 1'b0;
    repeat (5) tick();
    reset          = 1'b1;
    bus.car_passed = 1'b1;
    tick();
    reset          = 1'b0;
    bus.car_passed = 1'b0;
    check("rst2_gate", int'(bus.gate_open), 0);
    check("rst2_occ", int'(bus.occupancy), 0);
    check("rst2_empty", int'(bus.empty), 1);
    check("rst2_grant_pulse", int'(bus.grant_entry), 0);
    check("rst2_timeout", int'(bus.timeout), 0);

    // Exit from an empty lot is never granted; stray passage ignored.
    bus.exit_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_no_exit", int'(bus.grant_exit), 0);
    end
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    tick();
    check("stray_occ", int'(bus.occupancy), 0);
    check("stray_empty", int'(bus.empty), 1);

    // FSM is back in IDLE: a fresh entry is granted on the next edge.
    bus.entry_req = 1'b1;
    tick();
    check("idle_grant", int'(bus.grant_entry), 1);
    bus.entry_req = 1'b0;
    tick();
    check("idle_grant_pulse", int'(bus.grant_entry), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
